div_seq_ctrl: RTL
=================

Name: div_seq_ctrl

Overview:
- Sequencer between the EX stage and the shared multi-cycle divider.
- Accepts DIV/DIVU from EX, drives the divider start/operand handshake and holds operands stable for the whole operation.
- Stalls the pipeline until the quotient/remainder is captured, then issues a one-cycle HI/LO write.
- Handles flush mid-operation by draining the divider, which cannot abort, and discarding its result.

Parameters:
- MAX_WAIT, 40, cycles allowed from first start assertion to div_ready_i before the sticky error flag sets.

Ports:
- clk  in  1  clock
- rst  in  1  reset: synchronous, active-high
- ex_div_req_i  in  1  DIV/DIVU instruction present in EX
- ex_div_signed_i  in  1  1 = DIV (signed), 0 = DIVU
- ex_op1_i  in  32  dividend (rs)
- ex_op2_i  in  32  divisor (rt)
- flush_i  in  1  pipeline flush (exception/eret)
- stall_o  out  1  stall request to pipeline control
- div_start_o  out  1  divider start level (stop = 0)
- div_signed_o  out  1  divider signed select
- div_op1_o  out  32  divider operand 1
- div_op2_o  out  32  divider operand 2
- div_result_i  in  64  {remainder, quotient} from divider
- div_ready_i  in  1  divider result ready (level, held until start drops)
- hi_o  out  32  captured remainder
- lo_o  out  32  captured quotient
- hilo_we_o  out  1  one-cycle HI/LO write strobe
- div_err_o  out  1  sticky watchdog error

Behaviour:
- States: IDLE, BUSY, DONE, DRAIN, RELEASE.
- Reset:
  - state = IDLE.
  - hi_o, lo_o, hilo_we_o, div_err_o = 0.
  - Operand latches = 0.
  - Watchdog counter = 0.
  - rst mid-operation goes straight to IDLE. The divider shares rst, so no drain is needed.
- IDLE:
  - div_start_o = ex_div_req_i & ~flush_i.
  - Operands and signed select pass through combinationally from EX; latched on the same edge.
  - stall_o = div_start_o.
  - If started, go to BUSY.
- BUSY:
  - div_start_o = 1.
  - Operands and signed select come from the latches, so they stay stable for the full operation; the divider re-reads the operand signs at its final step.
  - stall_o = 1.
  - On div_ready_i = 1: capture hi_o = div_result_i[63:32] and lo_o = div_result_i[31:0], then go to DONE.
  - On flush_i = 1 (and not ready): go to DRAIN.
  - If ready and flush occur in the same cycle, flush wins: no capture, go to RELEASE.
- DONE:
  - div_start_o = 0, which returns the divider to free on this edge.
  - hilo_we_o = 1 for exactly this cycle.
  - stall_o = 0, so the div instruction advances at the end of this cycle.
  - Go to IDLE.
  - A new request may start the cycle after DONE (back-to-back). The req still asserted during DONE does not restart.
- DRAIN:
  - div_start_o = 1, operands from latches.
  - stall_o = ex_div_req_i, i.e. a new post-flush div waits.
  - Wait for div_ready_i, then go to RELEASE. The result is never captured and hilo_we_o stays 0.
- RELEASE:
  - div_start_o = 0.
  - stall_o = ex_div_req_i.
  - Go to IDLE.
- Latency:
  - The divider presents ready 20 cycles after start is first sampled (division by zero: 3 cycles).
  - stall_o is high from the request cycle through the cycle ready is seen.
  - hilo_we_o fires one cycle later.
- Watchdog:
  - Counts cycles in BUSY/DRAIN.
  - On reaching MAX_WAIT, set div_err_o (sticky until rst) and go to RELEASE.
- Divide by zero: result 0 in both halves. The controller does not special-case it unless the optional feature is enabled.
- flush_i in DONE: hilo_we_o is still issued; the write is architecturally older than the flush source.

Optional Feature:
- DIV_ZERO_FAST_EN.
- Defined:
  - In IDLE, a request with ex_op2_i == 0 does not assert div_start_o and goes directly to DONE.
  - stall_o = 1 in the request cycle.
  - hi_o = lo_o = 0 captured; hilo_we_o pulses the next cycle.
- Undefined: divide-by-zero is sent to the divider like any other request.

Test Plan:
- DIVU 100/7, no flush -> stall_o high about 21 cycles, one hilo_we_o pulse, hi_o = 2, lo_o = 14, div_start_o low in DONE.
- DIV 0xFFFFFFF9 (-7) / 2, with EX operands changed while BUSY -> divider operands stay latched, lo_o = 0xFFFFFFFD, hi_o = 0xFFFFFFFF.
- Flush 5 cycles after start of DIVU 50/5 -> state DRAIN, no hilo_we_o, hi_o/lo_o unchanged. A new DIVU 9/2 arriving during DRAIN stalls, then completes with lo_o = 4, hi_o = 1.
- Back-to-back DIVU 10/3 then 20/6 -> two hilo_we_o pulses; second start is asserted the cycle after DONE; results (1,3) then (2,3).
- DIVU 8/0 -> without macro, ready after 3 cycles and hi = lo = 0. With DIV_ZERO_FAST_EN, div_start_o never asserts and hilo_we_o pulses on cycle 2.
- Tie div_ready_i = 0, MAX_WAIT = 40 -> div_err_o set after 40 cycles and stays set; state IDLE after RELEASE. rst clears div_err_o.

Source files
------------

// File: rtl/div_seq_ctrl.sv
// Sequencer between the EX stage and the shared multi-cycle divider: holds operands, stalls EX,
// issues a one-cycle HI/LO write, and drains the divider on flush. Optional macro: DIV_ZERO_FAST_EN.
module div_seq_ctrl #(
   parameter int MAX_WAIT = 40
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ex_div_req_i,
   input  logic        ex_div_signed_i,
   input  logic [31:0] ex_op1_i,
   input  logic [31:0] ex_op2_i,
   input  logic        flush_i,
   output logic        stall_o,
   output logic        div_start_o,
   output logic        div_signed_o,
   output logic [31:0] div_op1_o,
   output logic [31:0] div_op2_o,
   input  logic [63:0] div_result_i,
   input  logic        div_ready_i,
   output logic [31:0] hi_o,
   output logic [31:0] lo_o,
   output logic        hilo_we_o,
   output logic        div_err_o,
   output logic [2:0]  dbg_state_o
);

   localparam int WDW = $clog2(MAX_WAIT + 1);
   localparam logic [WDW-1:0] WD_LAST = WDW'(MAX_WAIT - 1);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_BUSY    = 3'd1,
      S_DONE    = 3'd2,
      S_DRAIN   = 3'd3,
      S_RELEASE = 3'd4
   } state_t;

   state_t         r_state;
   state_t         w_next;
   logic           r_signed;
   logic [31:0]    r_op1;
   logic [31:0]    r_op2;
   logic [31:0]    r_hi;
   logic [31:0]    r_lo;
   logic           r_err;
   logic [WDW-1:0] r_wd_cnt;

   logic w_req;
   logic w_zero_fast;
   logic w_count;
   logic w_wd_hit;
   logic w_latch;
   logic w_capture;
   logic w_cap_zero;
   logic w_set_err;

   assign w_req = ex_div_req_i & ~flush_i;
`ifdef DIV_ZERO_FAST_EN
   assign w_zero_fast = w_req & (ex_op2_i == 32'd0);
`else
   assign w_zero_fast = 1'b0;
`endif
   assign w_count  = (r_state == S_BUSY) || (r_state == S_DRAIN);
   assign w_wd_hit = w_count && (r_wd_cnt == WD_LAST);

   // div_start_o is a level: the divider runs while it is high and holds div_ready_i until it drops.
   always_comb begin
      w_next       = r_state;
      div_start_o  = 1'b0;
      stall_o      = 1'b0;
      hilo_we_o    = 1'b0;
      div_signed_o = r_signed;
      div_op1_o    = r_op1;
      div_op2_o    = r_op2;
      w_latch      = 1'b0;
      w_capture    = 1'b0;
      w_cap_zero   = 1'b0;
      w_set_err    = 1'b0;
      case (r_state)
         S_IDLE: begin
            div_signed_o = ex_div_signed_i;
            div_op1_o    = ex_op1_i;
            div_op2_o    = ex_op2_i;
            if (w_zero_fast) begin
               stall_o    = 1'b1;
               w_cap_zero = 1'b1;
               w_next     = S_DONE;
            end else if (w_req) begin
               div_start_o = 1'b1;
               stall_o     = 1'b1;
               w_latch     = 1'b1;
               w_next      = S_BUSY;
            end
         end
         S_BUSY: begin
            div_start_o = 1'b1;
            stall_o     = 1'b1;
            // A flush coinciding with ready discards the result.
            if (div_ready_i && !flush_i) begin
               w_capture = 1'b1;
               w_next    = S_DONE;
            end else if (div_ready_i) begin
               w_next = S_RELEASE;
            end else if (w_wd_hit) begin
               w_set_err = 1'b1;
               w_next    = S_RELEASE;
            end else if (flush_i) begin
               w_next = S_DRAIN;
            end
         end
         S_DONE: begin
            hilo_we_o = 1'b1;
            w_next    = S_IDLE;
         end
         S_DRAIN: begin
            div_start_o = 1'b1;
            stall_o     = ex_div_req_i;
            if (div_ready_i) begin
               w_next = S_RELEASE;
            end else if (w_wd_hit) begin
               w_set_err = 1'b1;
               w_next    = S_RELEASE;
            end
         end
         S_RELEASE: begin
            stall_o = ex_div_req_i;
            w_next  = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= S_IDLE;
         r_signed <= 1'b0;
         r_op1    <= '0;
         r_op2    <= '0;
         r_hi     <= '0;
         r_lo     <= '0;
         r_err    <= 1'b0;
         r_wd_cnt <= '0;
      end else begin
         r_state <= w_next;
         if (w_latch) begin
            r_signed <= ex_div_signed_i;
            r_op1    <= ex_op1_i;
            r_op2    <= ex_op2_i;
         end
         if (w_capture) begin
            r_hi <= div_result_i[63:32];
            r_lo <= div_result_i[31:0];
         end else if (w_cap_zero) begin
            r_hi <= '0;
            r_lo <= '0;
         end
         if (w_set_err) r_err <= 1'b1;
         // Counts cycles with start asserted, including the IDLE start cycle.
         if (w_latch) r_wd_cnt <= WDW'(1);
         else if (w_count) r_wd_cnt <= r_wd_cnt + WDW'(1);
         else r_wd_cnt <= '0;
      end
   end

   assign hi_o        = r_hi;
   assign lo_o        = r_lo;
   assign div_err_o   = r_err;
   assign dbg_state_o = r_state;

endmodule
